// File: rtl/module_cpu_control.sv
// module_cpu_control
// Top-level sequencer for the Mini-CPU datapath. Walks the instruction cycle
// OFF -> FETCH -> DECODE -> READ -> CALC -> WAIT -> STORE -> SHOW and exposes
// the current state on stateCPU for the ALU. Latches an instruction word from
// the switches on a send-button rising edge, drives RAM writes (including the
// full register sweep used by CLEAR and by power-up) and the LCD refresh strobe.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   power               level, 1 = CPU on; 0 forces OFF on the next edge
//   send                debounced send pushbutton level
//   instr[17:0]         {opcode, dest, src1, src2} or {opcode, dest, src1, sign, imm}
//   decoded, calculated ALU handshakes closing DECODE and CALC
//   stateCPU[2:0]       current state encoding
//   opcode, sinalImm, Imm, addr_rd1, addr_rd2   latched instruction fields
//   addr_wr, ram_we     RAM write address / single-cycle write enable
//   clear_sel           1 while a register sweep is writing zeros
//   lcd_update          one-cycle LCD refresh strobe
//   error               sticky handshake-timeout flag
module module_cpu_control #(
    parameter int READ_LAT    = 2,
    parameter int SHOW_CYCLES = 4,
    parameter int TIMEOUT     = 15,
    parameter int NREGS       = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        power,
    input  logic        send,
    input  logic [17:0] instr,
    input  logic        decoded,
    input  logic        calculated,
    output logic [2:0]  stateCPU,
    output logic [2:0]  opcode,
    output logic        sinalImm,
    output logic [5:0]  Imm,
    output logic [3:0]  addr_rd1,
    output logic [3:0]  addr_rd2,
    output logic [3:0]  addr_wr,
    output logic        ram_we,
    output logic        clear_sel,
    output logic        lcd_update,
    output logic        error
);

    typedef enum logic [2:0] {
        S_OFF    = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_READ   = 3'd3,
        S_CALC   = 3'd4,
        S_WAIT   = 3'd5,
        S_STORE  = 3'd6,
        S_SHOW   = 3'd7
    } state_t;

    localparam logic [2:0] OP_CLEAR   = 3'd6;
    localparam logic [2:0] OP_DISPLAY = 3'd7;

    // Last in-state cycle index for each timed state (counter starts at 0).
    localparam logic [7:0] READ_LAST = 8'(READ_LAT - 1);
    localparam logic [7:0] SHOW_LAST = 8'(SHOW_CYCLES - 1);
    localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);
    localparam logic [7:0] CLR_LAST  = 8'(NREGS - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        sendPrev_q;
    logic        clearMode_q, clearMode_d;
    logic        error_q, error_d;
    logic [2:0]  opcode_q;
    logic [3:0]  dest_q, src1_q, src2_q;
    logic        sign_q;
    logic [5:0]  imm_q;
    logic        sendEdge;
    logic        latch;

    // Only a fresh press counts; holding the button down never retriggers.
    assign sendEdge = send & ~sendPrev_q;

    // Next-state logic. Power loss overrides everything. The shared counter
    // restarts on every state change, so it serves as the timeout counter in
    // DECODE/CALC, the latency counter in READ, the sweep address in STORE and
    // the dwell counter in SHOW.
    always_comb begin
        state_d     = state_q;
        clearMode_d = clearMode_q;
        error_d     = error_q;
        latch       = 1'b0;
        if (!power) begin
            state_d = S_OFF;
        end else begin
            case (state_q)
                S_OFF: begin
                    state_d     = S_STORE;
                    clearMode_d = 1'b1;
                end
                S_FETCH: begin
                    if (sendEdge) begin
                        state_d = S_DECODE;
                        latch   = 1'b1;
                        error_d = 1'b0;
                    end
                end
                S_DECODE: begin
                    if (decoded) begin
                        state_d = S_READ;
                    end else if (cnt_q == TO_LAST) begin
                        state_d = S_FETCH;
                        error_d = 1'b1;
                    end
                end
                S_READ: begin
                    if (cnt_q == READ_LAST) state_d = S_CALC;
                end
                S_CALC: begin
                    if (calculated) begin
                        state_d = S_WAIT;
                    end else if (cnt_q == TO_LAST) begin
                        state_d = S_FETCH;
                        error_d = 1'b1;
                    end
                end
                S_WAIT: begin
                    state_d     = S_STORE;
                    clearMode_d = (opcode_q == OP_CLEAR);
                end
                S_STORE: begin
                    if (!clearMode_q || cnt_q == CLR_LAST) state_d = S_SHOW;
                end
                S_SHOW: begin
                    if (cnt_q == SHOW_LAST) state_d = S_FETCH;
                end
                default: state_d = S_OFF;
            endcase
        end
        cnt_d = (state_d != state_q) ? 8'd0 : cnt_q + 8'd1;
    end

    // State, counter, handshake flags and the send edge detector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_OFF;
            cnt_q       <= 8'd0;
            sendPrev_q  <= 1'b0;
            clearMode_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sendPrev_q  <= send;
            clearMode_q <= clearMode_d;
            error_q     <= error_d;
        end
    end

    // Instruction fields are captured only when FETCH accepts a press and are
    // kept across power-off. src2 and {sign, imm} overlap in the word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode_q <= 3'd0;
            dest_q   <= 4'd0;
            src1_q   <= 4'd0;
            src2_q   <= 4'd0;
            sign_q   <= 1'b0;
            imm_q    <= 6'd0;
        end else if (latch) begin
            opcode_q <= instr[17:15];
            dest_q   <= instr[14:11];
            src1_q   <= instr[10:7];
            src2_q   <= instr[6:3];
            sign_q   <= instr[6];
            imm_q    <= instr[5:0];
        end
    end

    // Outputs decode directly from the registered state so they are glitch-free
    // relative to the state bus; write and strobe are gated by power so they
    // drop in the same cycle the supply goes away.
    always_comb begin
        stateCPU   = state_q;
        opcode     = opcode_q;
        sinalImm   = sign_q;
        Imm        = imm_q;
        addr_rd1   = src1_q;
        addr_rd2   = src2_q;
        error      = error_q;
        clear_sel  = (state_q == S_STORE) && clearMode_q;
        addr_wr    = clear_sel ? cnt_q[3:0] : dest_q;
        ram_we     = power && (state_q == S_STORE)
                     && (clearMode_q || opcode_q != OP_DISPLAY);
        lcd_update = power && (state_q == S_SHOW) && (cnt_q == 8'd0);
    end

endmodule

// File: tb/tb_module_cpu_control.sv
// Testbench for module_cpu_control. Stimulus pushes the expected state
// sequence (with dwell times), RAM writes and LCD strobes into queues; an
// independent monitor pops and compares whenever the DUT changes state,
// writes RAM or strobes the LCD.
module tb_module_cpu_control;

    logic        clk;
    logic        rst_n;
    logic        power;
    logic        send;
    logic [17:0] instrIn;
    logic        decoded;
    logic        calculated;
    logic [2:0]  stateCPU;
    logic [2:0]  opcode;
    logic        sinalImm;
    logic [5:0]  Imm;
    logic [3:0]  addr_rd1;
    logic [3:0]  addr_rd2;
    logic [3:0]  addr_wr;
    logic        ram_we;
    logic        clear_sel;
    logic        lcd_update;
    logic        error;

    localparam logic [2:0] OFF = 3'd0, FETCH = 3'd1, DECODE = 3'd2, READ = 3'd3,
                           CALC = 3'd4, WAIT = 3'd5, STORE = 3'd6, SHOW = 3'd7;

    typedef struct {
        logic [2:0] st;
        int         dur;
    } stExp_t;

    typedef struct {
        logic [3:0] addr;
        logic       clr;
    } wrExp_t;

    stExp_t stQ[$];
    wrExp_t wrQ[$];
    int     lcdQ[$];

    int checks = 0;
    int errors = 0;

    logic       monEn = 1'b0;
    logic [2:0] lastState = 3'd0;
    int         runLen = 0;
    logic       aluOn = 1'b1;
    logic       calcHold = 1'b0;
    stExp_t     monSt;
    wrExp_t     monWr;
    int         monLcd;

    module_cpu_control #(
        .READ_LAT(2), .SHOW_CYCLES(4), .TIMEOUT(15), .NREGS(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .power(power), .send(send), .instr(instrIn),
        .decoded(decoded), .calculated(calculated), .stateCPU(stateCPU),
        .opcode(opcode), .sinalImm(sinalImm), .Imm(Imm), .addr_rd1(addr_rd1),
        .addr_rd2(addr_rd2), .addr_wr(addr_wr), .ram_we(ram_we),
        .clear_sel(clear_sel), .lcd_update(lcd_update), .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU model: answers the handshake in the first cycle of DECODE/CALC
    // unless disabled (timeout) or held off (long CALC).
    always @(posedge clk) begin
        #1;
        decoded    = aluOn && (stateCPU == DECODE);
        calculated = aluOn && !calcHold && (stateCPU == CALC);
    end

    // Monitor: state changes, RAM writes and LCD strobes each pop an expectation.
    always @(negedge clk) begin
        if (monEn) begin
            if (stateCPU != lastState) begin
                checks++;
                if (stQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL stateSeq: got unexpected state %0d after %0d, none required", stateCPU, lastState);
                end else begin
                    monSt = stQ.pop_front();
                    if (stateCPU !== monSt.st) begin
                        errors++;
                        $display("[TB] FAIL stateSeq: got %0d, required %0d", stateCPU, monSt.st);
                    end
                    if (monSt.dur != 0) begin
                        checks++;
                        if (runLen != monSt.dur) begin
                            errors++;
                            $display("[TB] FAIL stateDur: state %0d lasted %0d cycles, required %0d", lastState, runLen, monSt.dur);
                        end
                    end
                end
                lastState = stateCPU;
                runLen    = 1;
            end else begin
                runLen++;
            end
            if (ram_we) begin
                checks++;
                if (wrQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL ramWrite: unexpected write addr=%0d clr=%0d", addr_wr, clear_sel);
                end else begin
                    monWr = wrQ.pop_front();
                    if (addr_wr !== monWr.addr || clear_sel !== monWr.clr) begin
                        errors++;
                        $display("[TB] FAIL ramWrite: got addr=%0d clr=%0d, required addr=%0d clr=%0d", addr_wr, clear_sel, monWr.addr, monWr.clr);
                    end
                end
            end
            if (lcd_update) begin
                checks++;
                if (lcdQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL lcdStrobe: unexpected strobe in state %0d cycle %0d", stateCPU, runLen);
                end else begin
                    monLcd = lcdQ.pop_front();
                    if (stateCPU !== SHOW || runLen != monLcd) begin
                        errors++;
                        $display("[TB] FAIL lcdStrobe: got state %0d cycle %0d, required state %0d cycle %0d", stateCPU, runLen, SHOW, monLcd);
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [17:0] word);
        instrIn = word;
        send    = 1'b1;
        @(negedge clk);
        send    = 1'b0;
    endtask

    task automatic waitState(input logic [2:0] s, input int maxCycles, input string name);
        int n = 0;
        while (stateCPU !== s && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, 32'(stateCPU), 32'(s));
    endtask

    task automatic pushState(input logic [2:0] s, input int dur);
        stExp_t e;
        e.st  = s;
        e.dur = dur;
        stQ.push_back(e);
    endtask

    task automatic pushWrite(input logic [3:0] a, input logic c);
        wrExp_t w;
        w.addr = a;
        w.clr  = c;
        wrQ.push_back(w);
    endtask

    task automatic pushSweep(input int count);
        for (int i = 0; i < count; i++) pushWrite(4'(i), 1'b1);
    endtask

    // Expectations for DECODE..SHOW..FETCH of a normally completing instruction.
    task automatic pushNormal(input logic [3:0] dest, input logic doWrite, input int calcDur);
        pushState(DECODE, 0);
        pushState(READ, 1);
        pushState(CALC, 2);
        pushState(WAIT, calcDur);
        pushState(STORE, 1);
        pushState(SHOW, 1);
        pushState(FETCH, 4);
        if (doWrite) pushWrite(dest, 1'b0);
        lcdQ.push_back(1);
    endtask

    initial begin
        rst_n      = 1'b0;
        power      = 1'b0;
        send       = 1'b0;
        instrIn    = 18'd0;
        decoded    = 1'b0;
        calculated = 1'b0;
        repeat (2) @(negedge clk);
        monEn = 1'b1;

        // Reset state
        checkOutput("rstState", 32'(stateCPU), 32'(OFF));
        checkOutput("rstRamWe", 32'(ram_we), 32'd0);
        checkOutput("rstClearSel", 32'(clear_sel), 32'd0);
        checkOutput("rstLcd", 32'(lcd_update), 32'd0);
        checkOutput("rstError", 32'(error), 32'd0);
        checkOutput("rstOpcode", 32'(opcode), 32'd0);
        checkOutput("rstImm", 32'(Imm), 32'd0);

        // Power-up sweep: STORE x16 clearing, SHOW x4, FETCH
        pushState(STORE, 0);
        pushSweep(16);
        pushState(SHOW, 16);
        lcdQ.push_back(1);
        pushState(FETCH, 4);
        rst_n = 1'b1;
        power = 1'b1;
        waitState(FETCH, 40, "powerUpFetch");

        // ADDI r3 = r1 + 5
        pushNormal(4'd3, 1'b1, 1);
        applyStimulus({3'd2, 4'd3, 4'd1, 1'b0, 6'd5});
        waitState(FETCH, 40, "addiFetch");
        checkOutput("addiOpcode", 32'(opcode), 32'd2);
        checkOutput("addiImm", 32'(Imm), 32'd5);
        checkOutput("addiRd1", 32'(addr_rd1), 32'd1);
        checkOutput("addiRd2", 32'(addr_rd2), 32'd0);
        checkOutput("addiSign", 32'(sinalImm), 32'd0);

        // DISPLAY: no write, one-cycle STORE
        pushNormal(4'd9, 1'b0, 1);
        applyStimulus({3'd7, 4'd9, 4'd2, 4'd4, 3'd0});
        waitState(FETCH, 40, "dispFetch");
        checkOutput("dispRd2", 32'(addr_rd2), 32'd4);
        checkOutput("dispImm", 32'(Imm), 32'd32);

        // Timeout in DECODE
        aluOn = 1'b0;
        pushState(DECODE, 0);
        pushState(FETCH, 15);
        applyStimulus({3'd1, 4'd5, 4'd10, 4'd12, 3'd3});
        waitState(FETCH, 40, "toFetch");
        checkOutput("toError", 32'(error), 32'd1);
        checkOutput("toImm", 32'(Imm), 32'd35);
        checkOutput("toSign", 32'(sinalImm), 32'd1);
        checkOutput("toRd1", 32'(addr_rd1), 32'd10);
        aluOn = 1'b1;

        // Send held for 50 cycles: exactly one ADD executes, error cleared
        pushNormal(4'd12, 1'b1, 1);
        instrIn = {3'd1, 4'd12, 4'd2, 4'd3, 3'd0};
        send    = 1'b1;
        repeat (50) @(negedge clk);
        send = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("heldState", 32'(stateCPU), 32'(FETCH));
        checkOutput("heldError", 32'(error), 32'd0);
        checkOutput("heldRd2", 32'(addr_rd2), 32'd3);

        // SUBI with a send pulse during a stretched CALC
        pushNormal(4'd7, 1'b1, 0);
        calcHold = 1'b1;
        applyStimulus({3'd5, 4'd7, 4'd4, 1'b1, 6'd9});
        waitState(CALC, 10, "subiCalc");
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        @(negedge clk);
        calcHold = 1'b0;
        waitState(FETCH, 40, "subiFetch");
        repeat (5) @(negedge clk);
        checkOutput("subiIdle", 32'(stateCPU), 32'(FETCH));
        checkOutput("subiSign", 32'(sinalImm), 32'd1);
        checkOutput("subiImm", 32'(Imm), 32'd9);
        checkOutput("subiRd2", 32'(addr_rd2), 32'd9);

        // CLEAR interrupted by power loss at address 7, then full resweep
        pushState(DECODE, 0);
        pushState(READ, 1);
        pushState(CALC, 2);
        pushState(WAIT, 1);
        pushState(STORE, 1);
        pushSweep(8);
        pushState(OFF, 8);
        applyStimulus({3'd6, 15'd0});
        begin
            int n = 0;
            while (!(stateCPU == STORE && addr_wr == 4'd7) && n < 60) begin
                @(negedge clk);
                n++;
            end
        end
        checkOutput("clrAddr7", 32'(addr_wr), 32'd7);
        #2;
        power = 1'b0;
        @(negedge clk);
        checkOutput("offState", 32'(stateCPU), 32'(OFF));
        checkOutput("offRamWe", 32'(ram_we), 32'd0);
        pushState(STORE, 0);
        pushSweep(16);
        pushState(SHOW, 16);
        lcdQ.push_back(1);
        pushState(FETCH, 4);
        power = 1'b1;
        waitState(FETCH, 60, "repowerFetch");

        repeat (5) @(negedge clk);
        checkOutput("stateQueueLeft", 32'(stQ.size()), 32'd0);
        checkOutput("writeQueueLeft", 32'(wrQ.size()), 32'd0);
        checkOutput("lcdQueueLeft", 32'(lcdQ.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
